// File: rtl/vliw_scoreboard.sv
// vliw_scoreboard: per-register bubble-count scoreboard for a lockstep VLIW
// issue stage. Detects RAW and WAW hazards against pending result latencies,
// stalls the whole bundle, and flags duplicate destinations in issued bundles.
module vliw_scoreboard #(
    parameter int NUM_LANES = 4,
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = 5,
    parameter int MAX_LAT   = 3,
    parameter int LAT_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bundle_valid,
    input  logic [NUM_LANES-1:0]        lane_en,
    input  logic [NUM_LANES*REG_AW-1:0] dc_rs1,
    input  logic [NUM_LANES*REG_AW-1:0] dc_rs2,
    input  logic [NUM_LANES*REG_AW-1:0] dc_rd,
    input  logic [NUM_LANES-1:0]        dc_rd_we,
    input  logic [NUM_LANES*LAT_W-1:0]  dc_lat,
    input  logic                        squash,
    output logic                        stall_out,
    output logic                        issued,
    output logic [NUM_REGS-1:0]         busy_mask,
    output logic                        dup_rd_err
);
    localparam logic [LAT_W-1:0] SAT_LAT = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0]     r_cnt [NUM_REGS];
    logic                 r_dup;

    logic [REG_AW-1:0]    w_rs1 [NUM_LANES];
    logic [REG_AW-1:0]    w_rs2 [NUM_LANES];
    logic [REG_AW-1:0]    w_rd  [NUM_LANES];
    logic [LAT_W-1:0]     w_lat [NUM_LANES];
    logic [LAT_W-1:0]     w_eff [NUM_LANES];
    logic [NUM_LANES-1:0] w_act;
    logic [NUM_LANES-1:0] w_wr;
    logic                 w_hazard;
    logic                 w_stall;
    logic                 w_issued;
    logic                 w_dup;
    logic [LAT_W-1:0]     w_cnt_nxt [NUM_REGS];

    // Unpack per-lane fields, qualify lanes, saturate requested latency
    always_comb begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            w_rs1[l] = dc_rs1[l*REG_AW +: REG_AW];
            w_rs2[l] = dc_rs2[l*REG_AW +: REG_AW];
            w_rd[l]  = dc_rd[l*REG_AW +: REG_AW];
            w_lat[l] = dc_lat[l*LAT_W +: LAT_W];
            w_eff[l] = (int'(w_lat[l]) > MAX_LAT) ? SAT_LAT : w_lat[l];
            w_act[l] = bundle_valid & lane_en[l];
            w_wr[l]  = w_act[l] & dc_rd_we[l] & (w_rd[l] != '0);
        end
    end

    // RAW/WAW hazard detection against pre-bundle counts; cnt[0] is always 0
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (w_act[l] && r_cnt[r] != '0 &&
                    (w_rs1[l] == REG_AW'(r) || w_rs2[l] == REG_AW'(r)))
                    w_hazard = 1'b1;
                if (w_wr[l] && w_rd[l] == REG_AW'(r) && r_cnt[r] > w_eff[l])
                    w_hazard = 1'b1;
            end
        end
    end

    // Issue control; squash and reset both suppress stall and issue
    always_comb begin
        w_stall  = rst & ~squash & w_hazard;
        w_issued = rst & bundle_valid & ~squash & ~w_stall;
    end

    // Two enabled writers of the same nonzero destination in one bundle
    always_comb begin
        w_dup = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            for (int unsigned j = i + 1; j < NUM_LANES; j++) begin
                if (w_wr[i] && w_wr[j] && w_rd[i] == w_rd[j])
                    w_dup = 1'b1;
            end
        end
    end

    // Next counts: drain by one, overridden by the highest-index issuing writer
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_cnt_nxt[r] = (r_cnt[r] != '0) ? r_cnt[r] - LAT_W'(1) : '0;
            if (w_issued) begin
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    if (w_wr[l] && w_rd[l] == REG_AW'(r))
                        w_cnt_nxt[r] = w_eff[l];
                end
            end
        end
    end

    // Counter and sticky duplicate-error state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
            r_dup <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= w_cnt_nxt[r];
            if (w_issued && w_dup)
                r_dup <= 1'b1;
        end
    end

    // Output views of registered state and combinational issue control
    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            busy_mask[r] = (r_cnt[r] != '0);
        stall_out  = w_stall;
        issued     = w_issued;
        dup_rd_err = r_dup;
    end

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Self-checking bench for vliw_scoreboard: a default 4-lane/32-reg instance and
// an 8-lane/64-reg instance with widened latency field. The reference model
// tracks, per register, the absolute cycle at which its result becomes usable.
module tb_vliw_scoreboard;
    localparam int MAXL = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A (defaults)
    logic        a_bv, a_sq, a_stall, a_iss, a_dup;
    logic [3:0]  a_en, a_we;
    logic [19:0] a_rs1, a_rs2, a_rd;
    logic [7:0]  a_lat;
    logic [31:0] a_busy;
    // instance B (8 lanes, 64 regs, 3-bit latency)
    logic        b_bv, b_sq, b_stall, b_iss, b_dup;
    logic [7:0]  b_en, b_we;
    logic [47:0] b_rs1, b_rs2, b_rd;
    logic [23:0] b_lat;
    logic [63:0] b_busy;

    vliw_scoreboard u_a (
        .clk(clk), .rst(rst), .bundle_valid(a_bv), .lane_en(a_en),
        .dc_rs1(a_rs1), .dc_rs2(a_rs2), .dc_rd(a_rd), .dc_rd_we(a_we),
        .dc_lat(a_lat), .squash(a_sq), .stall_out(a_stall), .issued(a_iss),
        .busy_mask(a_busy), .dup_rd_err(a_dup)
    );

    vliw_scoreboard #(
        .NUM_LANES(8), .NUM_REGS(64), .REG_AW(6), .MAX_LAT(3), .LAT_W(3)
    ) u_b (
        .clk(clk), .rst(rst), .bundle_valid(b_bv), .lane_en(b_en),
        .dc_rs1(b_rs1), .dc_rs2(b_rs2), .dc_rd(b_rd), .dc_rd_we(b_we),
        .dc_lat(b_lat), .squash(b_sq), .stall_out(b_stall), .issued(b_iss),
        .busy_mask(b_busy), .dup_rd_err(b_dup)
    );

    // stimulus for both instances, index [inst][lane]
    int bv [2];
    int sq [2];
    int en [2][8];
    int rs1 [2][8];
    int rs2 [2][8];
    int rd [2][8];
    int we [2][8];
    int lat [2][8];

    // reference model: ready cycle per register, sticky dup flag
    int ready [2][64];
    bit mdup [2];
    int now = 0;

    int n_vec = 0;
    int n_err = 0;

    function automatic int nl(int k); return (k == 0) ? 4 : 8; endfunction
    function automatic int nr(int k); return (k == 0) ? 32 : 64; endfunction
    function automatic int lmask(int k); return (k == 0) ? 3 : 7; endfunction

    function automatic int pend(int k, int r);
        return (ready[k][r] > now) ? ready[k][r] - now : 0;
    endfunction

    function automatic int eff(int k, int l);
        int v = lat[k][l] & lmask(k);
        return (v > MAXL) ? MAXL : v;
    endfunction

    function automatic bit active(int k, int l);
        return (bv[k] != 0) && (en[k][l] != 0);
    endfunction

    function automatic bit writer(int k, int l);
        return active(k, l) && (we[k][l] != 0) && (rd[k][l] != 0);
    endfunction

    function automatic bit exp_stall(int k);
        bit h = 1'b0;
        if (!rst || sq[k] != 0) return 1'b0;
        for (int l = 0; l < nl(k); l++) begin
            if (active(k, l)) begin
                if (rs1[k][l] != 0 && pend(k, rs1[k][l]) > 0) h = 1'b1;
                if (rs2[k][l] != 0 && pend(k, rs2[k][l]) > 0) h = 1'b1;
            end
            if (writer(k, l) && pend(k, rd[k][l]) > eff(k, l)) h = 1'b1;
        end
        return h;
    endfunction

    function automatic bit dup_now(int k);
        for (int i = 0; i < nl(k); i++)
            for (int j = i + 1; j < nl(k); j++)
                if (writer(k, i) && writer(k, j) && rd[k][i] == rd[k][j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear(int k);
        bv[k] = 0; sq[k] = 0;
        for (int l = 0; l < 8; l++) begin
            en[k][l] = 0; rs1[k][l] = 0; rs2[k][l] = 0;
            rd[k][l] = 0; we[k][l] = 0; lat[k][l] = 0;
        end
    endtask

    task automatic lane(int k, int l, int s1, int s2, int d, int w, int lt);
        bv[k] = 1; en[k][l] = 1; rs1[k][l] = s1; rs2[k][l] = s2;
        rd[k][l] = d; we[k][l] = w; lat[k][l] = lt;
    endtask

    task automatic set_rst(logic v);
        rst = v;
        if (!v) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 64; r++) ready[k][r] = 0;
                mdup[k] = 1'b0;
            end
        end
    endtask

    task automatic drive();
        a_bv = (bv[0] != 0); a_sq = (sq[0] != 0);
        b_bv = (bv[1] != 0); b_sq = (sq[1] != 0);
        for (int l = 0; l < 4; l++) begin
            a_en[l] = (en[0][l] != 0); a_we[l] = (we[0][l] != 0);
            a_rs1[l*5 +: 5] = 5'(rs1[0][l]); a_rs2[l*5 +: 5] = 5'(rs2[0][l]);
            a_rd[l*5 +: 5]  = 5'(rd[0][l]);  a_lat[l*2 +: 2] = 2'(lat[0][l]);
        end
        for (int l = 0; l < 8; l++) begin
            b_en[l] = (en[1][l] != 0); b_we[l] = (we[1][l] != 0);
            b_rs1[l*6 +: 6] = 6'(rs1[1][l]); b_rs2[l*6 +: 6] = 6'(rs2[1][l]);
            b_rd[l*6 +: 6]  = 6'(rd[1][l]);  b_lat[l*3 +: 3] = 3'(lat[1][l]);
        end
    endtask

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, now, obs, exp);
        end
    endtask

    // one clock: drive, check before the edge, advance the model at the edge
    task automatic cycle();
        bit ei [2];
        logic [63:0] eb;
        drive();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ei[k] = rst && (bv[k] != 0) && (sq[k] == 0) && !exp_stall(k);
            eb = '0;
            for (int r = 1; r < nr(k); r++) eb[r] = (pend(k, r) > 0);
            chk("stall",  k, 64'(k == 0 ? a_stall : b_stall), 64'(exp_stall(k)));
            chk("issued", k, 64'(k == 0 ? a_iss : b_iss),     64'(ei[k]));
            chk("busy",   k, (k == 0) ? {32'b0, a_busy} : b_busy, eb);
            chk("dup",    k, 64'(k == 0 ? a_dup : b_dup),     64'(mdup[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (ei[k]) begin
                if (dup_now(k)) mdup[k] = 1'b1;
                for (int l = 0; l < nl(k); l++)
                    if (writer(k, l)) ready[k][rd[k][l]] = now + 1 + eff(k, l);
            end
        end
        now++;
        #1;
    endtask

    initial begin
        set_rst(1'b0);
        clear(0); clear(1);

        // reset: bundle reading r5 held during reset, issues after release
        lane(0, 0, 5, 0, 0, 0, 0);
        lane(1, 0, 5, 0, 0, 0, 0);
        cycle(); cycle();
        set_rst(1'b1);
        cycle();

        // load-use on both instances: lane2 writes r7 lat1, lane0 reads r7
        for (int k = 0; k < 2; k++) begin clear(k); lane(k, 2, 0, 0, 7, 1, 1); end
        cycle();
        for (int k = 0; k < 2; k++) begin clear(k); lane(k, 0, 7, 0, 0, 0, 0); end
        cycle(); cycle();

        // latency 3 then WAW with lat 0 on r9
        clear(0); clear(1); lane(0, 0, 0, 0, 9, 1, 3);
        cycle();
        clear(0); lane(0, 1, 0, 0, 9, 1, 0);
        repeat (4) cycle();

        // squash of a dependent bundle while r4 drains
        clear(0); lane(0, 0, 0, 0, 4, 1, 2);
        cycle();
        clear(0); lane(0, 0, 4, 0, 0, 0, 0); sq[0] = 1;
        cycle();
        sq[0] = 0;
        cycle(); cycle();

        // duplicate rd (lanes 1 and 3 on r6) and writes to r0, both instances
        for (int k = 0; k < 2; k++) begin
            clear(k); lane(k, 1, 0, 0, 6, 1, 0); lane(k, 3, 0, 0, 6, 1, 2);
        end
        cycle();
        for (int k = 0; k < 2; k++) begin clear(k); lane(k, 0, 0, 0, 0, 1, 3); lane(k, 2, 0, 0, 0, 1, 3); end
        cycle();
        clear(0); clear(1);
        repeat (3) cycle();

        // saturation on the wide instance: lat 7 clamps to 3, then reader waits
        clear(1); lane(1, 5, 0, 0, 40, 1, 7);
        cycle();
        clear(1); lane(1, 7, 0, 40, 0, 0, 0);
        repeat (4) cycle();

        // reset mid-drain clears counts; first bundle after reset issues
        clear(0); clear(1); lane(0, 0, 0, 0, 12, 1, 3); lane(1, 0, 0, 0, 12, 1, 3);
        cycle();
        set_rst(1'b0);
        clear(0); clear(1);
        cycle();
        set_rst(1'b1);
        lane(0, 0, 12, 0, 0, 0, 0); lane(1, 0, 12, 0, 0, 0, 0);
        cycle();

        // randomized traffic with frequent register reuse
        for (int n = 0; n < 600; n++) begin
            if (!rst) set_rst(1'b1);
            else if ($urandom_range(0, 149) == 0) set_rst(1'b0);
            for (int k = 0; k < 2; k++) begin
                clear(k);
                bv[k] = ($urandom_range(0, 9) < 8) ? 1 : 0;
                sq[k] = ($urandom_range(0, 9) == 0) ? 1 : 0;
                for (int l = 0; l < nl(k); l++) begin
                    en[k][l]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                    we[k][l]  = ($urandom_range(0, 4) < 3) ? 1 : 0;
                    lat[k][l] = int'($urandom_range(0, lmask(k)));
                    if (k == 0) begin
                        rs1[k][l] = int'($urandom_range(0, 11));
                        rs2[k][l] = int'($urandom_range(0, 11));
                        rd[k][l]  = int'($urandom_range(0, 11));
                    end else begin
                        rs1[k][l] = int'($urandom_range(0, 7)) + (($urandom_range(0, 1) != 0) ? 56 : 0);
                        rs2[k][l] = int'($urandom_range(0, 7)) + (($urandom_range(0, 1) != 0) ? 56 : 0);
                        rd[k][l]  = int'($urandom_range(0, 7)) + (($urandom_range(0, 1) != 0) ? 56 : 0);
                    end
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
